// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM sequencing FETCH/DECODE/EXEC/MEM/WB
// and driving the ALU operation code and datapath enables.
module mc_ctrl #(
   parameter int MEM_LAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [3:0] alu_op,
   output logic       alu_src_b,
   output logic       ext_op,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       instr_done,
   output logic [2:0] state
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
   typedef enum logic [3:0] {C_ADDU, C_SUBU, C_SLT, C_ORI, C_LW, C_SW, C_LUI, C_BEQ, C_J, C_ILL} cls_t;

   localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_cnt;
   cls_t       w_cls;
   logic       w_last;
   logic       w_rtype;
   logic [3:0] w_aop;
   logic       w_src_b;
   logic       w_ext;
   logic [3:0] w_alu_op;
   logic       w_alu_src_b;
   logic       w_ext_op;
   logic       w_ir_write;
   logic       w_pc_write;
   logic [1:0] w_pc_src;
   logic       w_mem_write;
   logic       w_reg_write;
   logic       w_reg_dst;
   logic       w_mem_to_reg;
   logic       w_instr_done;

   always_comb begin
      w_cls = C_ILL;
      case (opcode)
         6'b000000: w_cls = (funct == 6'b100001) ? C_ADDU :
                            (funct == 6'b100011) ? C_SUBU :
                            (funct == 6'b101010) ? C_SLT  : C_ILL;
         6'b001101: w_cls = C_ORI;
         6'b100011: w_cls = C_LW;
         6'b101011: w_cls = C_SW;
         6'b001111: w_cls = C_LUI;
         6'b000100: w_cls = C_BEQ;
         6'b000010: w_cls = C_J;
         default:   w_cls = C_ILL;
      endcase
   end

   assign w_rtype = (w_cls == C_ADDU) || (w_cls == C_SUBU) || (w_cls == C_SLT);
   assign w_last  = (r_cnt == CNT_LAST);

   // ALU controls for the decoded class; held unchanged through EXEC, MEM and WB
   always_comb begin
      w_aop = 4'd0;
      case (w_cls)
         C_SUBU:  w_aop = 4'd1;
         C_BEQ:   w_aop = 4'd1;
         C_ORI:   w_aop = 4'd2;
         C_SLT:   w_aop = 4'd3;
         C_LW:    w_aop = 4'd4;
         C_SW:    w_aop = 4'd5;
         C_LUI:   w_aop = 4'd6;
         default: w_aop = 4'd0;
      endcase
   end

   assign w_src_b = (w_cls == C_ORI) || (w_cls == C_LUI) || (w_cls == C_LW) || (w_cls == C_SW);
   assign w_ext   = (w_cls == C_LW) || (w_cls == C_SW) || (w_cls == C_BEQ);

   always_comb begin
      w_next       = FETCH;
      w_alu_op     = 4'd0;
      w_alu_src_b  = 1'b0;
      w_ext_op     = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = 2'd0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_instr_done = 1'b0;
      case (r_state)
         FETCH: begin
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
            w_next     = DECODE;
         end
         DECODE: begin
            w_instr_done = (w_cls == C_ILL);
            w_next       = (w_cls == C_ILL) ? FETCH : EXEC;
         end
         EXEC: begin
            w_alu_op     = w_aop;
            w_alu_src_b  = w_src_b;
            w_ext_op     = w_ext;
            w_pc_write   = (w_cls == C_J) || ((w_cls == C_BEQ) && zero);
            w_pc_src     = (w_cls == C_J) ? 2'd2 : (w_cls == C_BEQ) ? 2'd1 : 2'd0;
            w_instr_done = (w_cls == C_J) || (w_cls == C_BEQ);
            w_next       = ((w_cls == C_LW) || (w_cls == C_SW)) ? MEM :
                           (w_rtype || (w_cls == C_ORI) || (w_cls == C_LUI)) ? WB : FETCH;
         end
         MEM: begin
            w_alu_op     = w_aop;
            w_alu_src_b  = w_src_b;
            w_ext_op     = w_ext;
            w_mem_write  = w_last && (w_cls == C_SW);
            w_instr_done = w_last && (w_cls == C_SW);
            w_next       = !w_last ? MEM : (w_cls == C_SW) ? FETCH : WB;
         end
         WB: begin
            w_alu_op     = w_aop;
            w_alu_src_b  = w_src_b;
            w_ext_op     = w_ext;
            w_reg_write  = 1'b1;
            w_reg_dst    = w_rtype;
            w_mem_to_reg = (w_cls == C_LW);
            w_instr_done = 1'b1;
         end
         default: w_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FETCH;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= ((r_state == MEM) && !w_last) ? r_cnt + 4'd1 : 4'd0;
      end
   end

   // reset gates every enable combinationally so an aborted instruction can never write
   assign {alu_op, alu_src_b, ext_op, ir_write, pc_write, pc_src, mem_write,
           reg_write, reg_dst, mem_to_reg, instr_done} =
      reset ? 15'd0 : {w_alu_op, w_alu_src_b, w_ext_op, w_ir_write, w_pc_write, w_pc_src,
                       w_mem_write, w_reg_write, w_reg_dst, w_mem_to_reg, w_instr_done};
   assign state = r_state;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: runs three controllers (MEM_LAT 1, 3, 4) in lockstep on shared stimulus
// and checks every cycle against an instruction-level reference model.
module tb_mc_ctrl;
   typedef struct packed {
      logic [3:0] alu_op;
      logic       src_b;
      logic       ext;
      logic       ir_w;
      logic       pc_w;
      logic [1:0] pc_src;
      logic       mem_w;
      logic       reg_w;
      logic       reg_dst;
      logic       m2r;
      logic       done;
      logic [2:0] st;
   } vec_t;

   typedef enum {K_ADDU, K_SUBU, K_SLT, K_ORI, K_LW, K_SW, K_LUI, K_BEQ, K_J, K_ILL} kind_t;

   localparam int LATS [3] = '{1, 3, 4};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   vec_t       obs [3];
   vec_t       seq [3][$];
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [3:0] alu_op;
      logic       alu_src_b, ext_op, ir_write, pc_write, mem_write, reg_write, reg_dst, mem_to_reg, instr_done;
      logic [1:0] pc_src;
      logic [2:0] state;
      mc_ctrl #(.MEM_LAT(LATS[g])) u_dut (
         .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
         .alu_op(alu_op), .alu_src_b(alu_src_b), .ext_op(ext_op), .ir_write(ir_write),
         .pc_write(pc_write), .pc_src(pc_src), .mem_write(mem_write), .reg_write(reg_write),
         .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done), .state(state)
      );
      assign obs[g] = {alu_op, alu_src_b, ext_op, ir_write, pc_write, pc_src, mem_write,
                       reg_write, reg_dst, mem_to_reg, instr_done, state};
   end

   function automatic kind_t decode(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'b000000)
         return (fn == 6'b100001) ? K_ADDU : (fn == 6'b100011) ? K_SUBU : (fn == 6'b101010) ? K_SLT : K_ILL;
      case (op)
         6'b001101: return K_ORI;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b001111: return K_LUI;
         6'b000100: return K_BEQ;
         6'b000010: return K_J;
         default:   return K_ILL;
      endcase
   endfunction

   function automatic logic [3:0] aop(input kind_t k);
      case (k)
         K_SUBU, K_BEQ: return 4'd1;
         K_ORI:         return 4'd2;
         K_SLT:         return 4'd3;
         K_LW:          return 4'd4;
         K_SW:          return 4'd5;
         K_LUI:         return 4'd6;
         default:       return 4'd0;
      endcase
   endfunction

   function automatic int lat_of(input kind_t k, input int l);
      case (k)
         K_ILL:      return 2;
         K_BEQ, K_J: return 3;
         K_LW:       return 4 + l;
         K_SW:       return 3 + l;
         default:    return 4;
      endcase
   endfunction

   // expected per-cycle outputs of one complete instruction
   function automatic void build(input int g, input kind_t k, input logic z, input int l);
      vec_t v, e;
      logic rt;
      rt = (k == K_ADDU) || (k == K_SUBU) || (k == K_SLT);
      seq[g].delete();
      v = '0; v.ir_w = 1'b1; v.pc_w = 1'b1; v.st = 3'd0;
      seq[g].push_back(v);
      v = '0; v.st = 3'd1; v.done = (k == K_ILL);
      seq[g].push_back(v);
      if (k == K_ILL) return;
      e = '0; e.st = 3'd2; e.alu_op = aop(k);
      e.src_b = (k == K_ORI) || (k == K_LUI) || (k == K_LW) || (k == K_SW);
      e.ext = (k == K_LW) || (k == K_SW) || (k == K_BEQ);
      v = e;
      if (k == K_BEQ) begin v.pc_w = z; v.pc_src = 2'd1; v.done = 1'b1; end
      if (k == K_J) begin v.pc_w = 1'b1; v.pc_src = 2'd2; v.done = 1'b1; end
      seq[g].push_back(v);
      if ((k == K_BEQ) || (k == K_J)) return;
      if ((k == K_LW) || (k == K_SW))
         for (int i = 0; i < l; i++) begin
            v = e; v.st = 3'd3;
            if ((k == K_SW) && (i == l - 1)) begin v.mem_w = 1'b1; v.done = 1'b1; end
            seq[g].push_back(v);
         end
      if (k == K_SW) return;
      v = e; v.st = 3'd4; v.reg_w = 1'b1; v.done = 1'b1; v.reg_dst = rt; v.m2r = (k == K_LW);
      seq[g].push_back(v);
   endfunction

   // Repeats one instruction back-to-back for ncyc cycles; optional reset after cycle rst_at.
   task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int ncyc, input int rst_at);
      int pos [3];
      int since [3];
      kind_t k;
      k = decode(op, fn);
      for (int g = 0; g < 3; g++) build(g, k, z, LATS[g]);
      opcode = op; funct = fn; zero = z; reset = 1'b1;
      for (int c = 0; c <= ncyc; c++) begin
         if (reset) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
               total++;
               if (obs[g] !== vec_t'(0)) begin
                  bad++; $display("FAIL %s reset dut%0d got=%h exp=%h", name, g, obs[g], vec_t'(0));
               end
            end
            reset = 1'b0;
            #1;
            for (int g = 0; g < 3; g++) begin
               total++;
               if (obs[g] !== seq[g][0]) begin
                  bad++; $display("FAIL %s fetch_after_reset dut%0d got=%h exp=%h", name, g, obs[g], seq[g][0]);
               end
               pos[g] = 1 % seq[g].size();
               since[g] = 1;
            end
         end
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            since[g]++;
            total++;
            if (obs[g] !== seq[g][pos[g]]) begin
               bad++; $display("FAIL %s cycle%0d dut%0d got=%h exp=%h", name, c, g, obs[g], seq[g][pos[g]]);
            end
            pos[g] = (pos[g] + 1) % seq[g].size();
            if (obs[g].done === 1'b1) begin
               total++;
               if (since[g] != lat_of(k, LATS[g])) begin
                  bad++; $display("FAIL %s latency dut%0d got=%0d exp=%0d", name, g, since[g], lat_of(k, LATS[g]));
               end
               since[g] = 0;
            end
         end
         if (c == rst_at) begin
            reset = 1'b1;
            #1;
            for (int g = 0; g < 3; g++) begin
               total++;
               if ((obs[g] & 18'h3FFF8) !== 18'h0) begin
                  bad++; $display("FAIL %s gated_by_reset dut%0d got=%h exp=0 (state ignored)", name, g, obs[g]);
               end
            end
         end
      end
   endtask

   task automatic test_reset();       run("reset_nop", 6'b000000, 6'b000000, 1'b0, 6, -1); endtask
   task automatic test_addu();        run("addu", 6'b000000, 6'b100001, 1'b0, 12, -1); endtask
   task automatic test_rtype();
      run("subu", 6'b000000, 6'b100011, 1'b1, 9, -1);
      run("slt", 6'b000000, 6'b101010, 1'b0, 9, -1);
      run("ori", 6'b001101, 6'b000000, 1'b0, 9, -1);
      run("lui", 6'b001111, 6'b111111, 1'b0, 9, -1);
   endtask
   task automatic test_lw();          run("lw", 6'b100011, 6'b000000, 1'b0, 24, -1); endtask
   task automatic test_sw();          run("sw", 6'b101011, 6'b000000, 1'b0, 24, -1); endtask
   task automatic test_beq();
      run("beq_taken", 6'b000100, 6'b000000, 1'b1, 10, -1);
      run("beq_not_taken", 6'b000100, 6'b000000, 1'b0, 10, -1);
   endtask
   task automatic test_j();           run("j", 6'b000010, 6'b000000, 1'b0, 10, -1); endtask
   task automatic test_illegal();     run("illegal", 6'b111111, 6'b000000, 1'b0, 8, -1); endtask
   task automatic test_reset_mid_sw(); run("reset_mid_sw", 6'b101011, 6'b000000, 1'b0, 16, 4); endtask

   task automatic test_back_to_back_random();
      logic [5:0] ops [10] = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b100011,
                                6'b101011, 6'b001111, 6'b000100, 6'b000010, 6'b000000};
      logic [5:0] fns [10] = '{6'b100001, 6'b100011, 6'b101010, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
      int idx, n;
      logic [5:0] op, fn;
      for (int t = 0; t < 30; t++) begin
         idx = $urandom_range(0, 10);
         op = (idx == 10) ? 6'($urandom) : ops[idx];
         fn = (idx == 10) ? 6'($urandom) : fns[idx];
         n = $urandom_range(6, 20);
         run("random", op, fn, 1'($urandom), n, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1);
      end
   endtask

   initial begin
      test_reset();
      test_addu();
      test_rtype();
      test_lw();
      test_sw();
      test_beq();
      test_j();
      test_illegal();
      test_reset_mid_sw();
      test_back_to_back_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
